morse_tx_encoder: RTL and testbench

Morse transmitter; the counterpart of the key-driven Morse receiver. It accepts one 5-bit character code per handshake, using the same code space as the receiver's display buffer: A=0 … Z=25, 31=space. It plays the code on the buzzer output with standard Morse unit timing. It sits between the message source (playback/echo logic) and the board buzzer/LED.

---
 rtl/morse_pkg.sv | 37 +++
 rtl/morse_tx_encoder_if.sv | 12 +
 rtl/morse_code_rom.sv | 50 +++++
 rtl/morse_tx_encoder.sv | 145 ++++++++++++++
 tb/tb_morse_tx_encoder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse code constants, FSM state type and unit lengths
//
// Purpose: character-code space shared with the Morse receiver, transmitter
// FSM states, element/gap lengths in Morse units, and a pattern alignment helper.
package morse_pkg;

  // Character codes, same code space as the receiver display buffer
  localparam logic [4:0] CH_A = 5'd0,  CH_B = 5'd1,  CH_C = 5'd2,  CH_D = 5'd3;
  localparam logic [4:0] CH_E = 5'd4,  CH_F = 5'd5,  CH_G = 5'd6,  CH_H = 5'd7;
  localparam logic [4:0] CH_I = 5'd8,  CH_J = 5'd9,  CH_K = 5'd10, CH_L = 5'd11;
  localparam logic [4:0] CH_M = 5'd12, CH_N = 5'd13, CH_O = 5'd14, CH_P = 5'd15;
  localparam logic [4:0] CH_Q = 5'd16, CH_R = 5'd17, CH_S = 5'd18, CH_T = 5'd19;
  localparam logic [4:0] CH_U = 5'd20, CH_V = 5'd21, CH_W = 5'd22, CH_X = 5'd23;
  localparam logic [4:0] CH_Y = 5'd24, CH_Z = 5'd25, CH_SPACE = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_ELEM_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } morse_state_e;

  // Phase lengths in Morse units
  localparam logic [2:0] DOT_U      = 3'd1;
  localparam logic [2:0] DASH_U     = 3'd3;
  localparam logic [2:0] ELEM_GAP_U = 3'd1;
  localparam logic [2:0] CHAR_GAP_U = 3'd3;
  localparam logic [2:0] WORD_GAP_U = 3'd7;

  // Move the first-sent element (pattern[len-1]) up to bit 3 so the FSM
  // always reads the current element from the MSB of its shift register.
  function automatic logic [3:0] align_msb(input logic [3:0] pattern, input logic [2:0] len);
    return pattern << (3'd4 - len);
  endfunction

endpackage

// File: rtl/morse_tx_encoder_if.sv
// rtl/morse_tx_encoder_if.sv - character handshake between message source and Morse transmitter
//
// Signals: iChar (5-bit character code), iValid (code valid), oReady (transmitter idle and enabled).
// master = message source, slave = transmitter.
interface morse_tx_encoder_if;
  logic [4:0] iChar;
  logic       iValid;
  logic       oReady;

  modport master (output iChar, output iValid, input oReady);
  modport slave  (input iChar, input iValid, output oReady);
endinterface

// File: rtl/morse_code_rom.sv
// rtl/morse_code_rom.sv - combinational character code to Morse element pattern table
//
// Ports: iChar (5-bit code) -> oLen (element count 1..4, 0 for space/illegal),
// oPattern (bit 1 = dash, pattern[len-1] sent first), oIllegal (codes 26..30).
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [4:0] iChar,
  output logic [2:0] oLen,
  output logic [3:0] oPattern,
  output logic       oIllegal
);

  always_comb begin
    oLen     = 3'd0;
    oPattern = 4'b0000;
    oIllegal = 1'b0;
    case (iChar)
      CH_A: {oLen, oPattern} = {3'd2, 4'b0001};
      CH_B: {oLen, oPattern} = {3'd4, 4'b1000};
      CH_C: {oLen, oPattern} = {3'd4, 4'b1010};
      CH_D: {oLen, oPattern} = {3'd3, 4'b0100};
      CH_E: {oLen, oPattern} = {3'd1, 4'b0000};
      CH_F: {oLen, oPattern} = {3'd4, 4'b0010};
      CH_G: {oLen, oPattern} = {3'd3, 4'b0110};
      CH_H: {oLen, oPattern} = {3'd4, 4'b0000};
      CH_I: {oLen, oPattern} = {3'd2, 4'b0000};
      CH_J: {oLen, oPattern} = {3'd4, 4'b0111};
      CH_K: {oLen, oPattern} = {3'd3, 4'b0101};
      CH_L: {oLen, oPattern} = {3'd4, 4'b0100};
      CH_M: {oLen, oPattern} = {3'd2, 4'b0011};
      CH_N: {oLen, oPattern} = {3'd2, 4'b0010};
      CH_O: {oLen, oPattern} = {3'd3, 4'b0111};
      CH_P: {oLen, oPattern} = {3'd4, 4'b0110};
      CH_Q: {oLen, oPattern} = {3'd4, 4'b1101};
      CH_R: {oLen, oPattern} = {3'd3, 4'b0010};
      CH_S: {oLen, oPattern} = {3'd3, 4'b0000};
      CH_T: {oLen, oPattern} = {3'd1, 4'b0001};
      CH_U: {oLen, oPattern} = {3'd3, 4'b0001};
      CH_V: {oLen, oPattern} = {3'd4, 4'b0001};
      CH_W: {oLen, oPattern} = {3'd3, 4'b0011};
      CH_X: {oLen, oPattern} = {3'd4, 4'b1001};
      CH_Y: {oLen, oPattern} = {3'd4, 4'b1011};
      CH_Z: {oLen, oPattern} = {3'd4, 4'b1100};
      CH_SPACE: {oLen, oPattern} = {3'd0, 4'b0000};
      default: oIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/morse_tx_encoder.sv
// rtl/morse_tx_encoder.sv - Morse transmitter driving the buzzer with standard unit timing
//
// Ports: iCLK, iRST_n (sync, active low), iEnable (low aborts), char_if (slave handshake:
// iChar/iValid/oReady), oBuzzer (tone on), oBusy (character or gap in progress),
// oErr (one-cycle pulse when an illegal code is accepted and dropped).
module morse_tx_encoder #(
  parameter int UNIT_CYCLES = 3000000,
  parameter int CNT_W       = 22
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iEnable,
  morse_tx_encoder_if.slave char_if,
  output logic              oBuzzer,
  output logic              oBusy,
  output logic              oErr
);
  import morse_pkg::*;

  localparam logic [CNT_W-1:0] UNIT_LOAD = CNT_W'(UNIT_CYCLES - 1);

  morse_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt;          // cycles left in the current unit
  logic [2:0]       units;        // units left in the current phase after this one
  logic [2:0]       load_units;
  logic             load;
  logic [3:0]       sh;           // remaining elements, current one at bit 3
  logic [1:0]       rem;          // elements left after the current one
  logic             err_q;
  logic             accept;
  logic             phase_done;

  logic [2:0] rom_len;
  logic [3:0] rom_pat;
  logic       rom_ill;
  logic [3:0] rom_aligned;

  morse_code_rom u_rom (
    .iChar    (char_if.iChar),
    .oLen     (rom_len),
    .oPattern (rom_pat),
    .oIllegal (rom_ill)
  );

  assign rom_aligned = align_msb(rom_pat, rom_len);
  assign accept      = char_if.iValid && char_if.oReady;
  assign phase_done  = (cnt == '0) && (units == 3'd0);

  // State register
  always_ff @(posedge iCLK) begin
    if (!iRST_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; also selects the length of the phase being entered
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_units = 3'd0;
    case (state)
      ST_IDLE: begin
        if (accept && !rom_ill) begin
          load = 1'b1;
          if (rom_len == 3'd0) begin
            state_nxt  = ST_WORD_GAP;
            load_units = WORD_GAP_U - 3'd1;
          end else begin
            state_nxt  = ST_MARK;
            load_units = rom_aligned[3] ? DASH_U - 3'd1 : DOT_U - 3'd1;
          end
        end
      end
      ST_MARK: begin
        if (phase_done) begin
          load = 1'b1;
          if (rem == 2'd0) begin
            state_nxt  = ST_CHAR_GAP;
            load_units = CHAR_GAP_U - 3'd1;
          end else begin
            state_nxt  = ST_ELEM_GAP;
            load_units = ELEM_GAP_U - 3'd1;
          end
        end
      end
      ST_ELEM_GAP: begin
        if (phase_done) begin
          load       = 1'b1;
          state_nxt  = ST_MARK;
          // sh[2] is the element that becomes current after the shift
          load_units = sh[2] ? DASH_U - 3'd1 : DOT_U - 3'd1;
        end
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (phase_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Dropping the enable abandons the character without flagging an error
    if (!iEnable && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      load      = 1'b0;
    end
  end

  // Unit timing, element shift register and error pulse
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      cnt   <= '0;
      units <= 3'd0;
      sh    <= 4'b0000;
      rem   <= 2'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= accept && rom_ill;
      if (state_nxt == ST_IDLE) begin
        cnt   <= '0;
        units <= 3'd0;
      end else if (load) begin
        cnt   <= UNIT_LOAD;
        units <= load_units;
      end else if (cnt == '0) begin
        cnt   <= UNIT_LOAD;
        units <= units - 3'd1;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
      if (accept) begin
        sh  <= rom_aligned;
        rem <= rom_len[1:0] - 2'd1;
      end else if (state == ST_ELEM_GAP && state_nxt == ST_MARK) begin
        sh  <= {sh[2:0], 1'b0};
        rem <= rem - 2'd1;
      end
    end
  end

  // Outputs
  always_comb begin
    char_if.oReady = (state == ST_IDLE) && iEnable && iRST_n;
    oBuzzer        = (state == ST_MARK);
    oBusy          = (state != ST_IDLE);
    oErr           = err_q;
  end

endmodule

// File: tb/tb_morse_tx_encoder.sv
// tb/tb_morse_tx_encoder.sv - scoreboard bench for morse_tx_encoder
module tb_morse_tx_encoder;

  localparam int U = 4;

  // Expected output word: {oBuzzer, oBusy, oReady, oErr}
  localparam logic [3:0] MARK_E = 4'b1100;
  localparam logic [3:0] GAP_E  = 4'b0100;
  localparam logic [3:0] RDY_E  = 4'b0010;
  localparam logic [3:0] OFF_E  = 4'b0000;
  localparam logic [3:0] ERR_E  = 4'b0011;

  logic iCLK = 1'b0;
  logic iRST_n;
  logic iEnable;
  logic oBuzzer, oBusy, oErr;
  logic [3:0] dut_out;

  morse_tx_encoder_if bus ();

  morse_tx_encoder #(.UNIT_CYCLES(U), .CNT_W(3)) dut (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iEnable (iEnable),
    .char_if (bus),
    .oBuzzer (oBuzzer),
    .oBusy   (oBusy),
    .oErr    (oErr)
  );

  always #5 iCLK = ~iCLK;

  assign dut_out = {oBuzzer, oBusy, bus.oReady, oErr};

  string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  logic [3:0] sb [$];
  int n_tests = 0;
  int n_fail  = 0;
  int cur_code = 0;
  int samp = 0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got={buz,busy,rdy,err}=%b want=%b", tag, got, exp);
    end
  endtask

  task automatic push_n(input logic [3:0] e, input int n);
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Expected waveform from the cycle after the accept edge up to the first ready cycle
  task automatic push_char(input int code);
    string s;
    byte c;
    if (code >= 26 && code <= 30) begin
      push_n(ERR_E, 1);
      push_n(RDY_E, 1);
    end else if (code == 31) begin
      push_n(GAP_E, 7 * U);
      push_n(RDY_E, 1);
    end else begin
      s = morse[code];
      for (int i = 0; i < s.len(); i++) begin
        c = s[i];
        push_n(MARK_E, (c == 8'h2d) ? 3 * U : U);
        if (i < s.len() - 1) push_n(GAP_E, U);
      end
      push_n(GAP_E, 3 * U);
      push_n(RDY_E, 1);
    end
  endtask

  always @(negedge iCLK) begin : monitor
    logic [3:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      samp++;
      chk($sformatf("c%0d_s%0d", cur_code, samp), dut_out, e);
    end
  end

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge iCLK);
      n++;
    end
  endtask

  // Drive one code, push its expectation at the accept edge
  task automatic start(input int code);
    @(posedge iCLK);
    #1;
    bus.iChar  = 5'(code);
    bus.iValid = 1'b1;
    cur_code   = code;
    samp       = 0;
    @(posedge iCLK);
  endtask

  task automatic send(input int code);
    start(code);
    push_char(code);
    #1 bus.iValid = 1'b0;
    wait_empty();
  endtask

  initial begin
    iRST_n     = 1'b0;
    iEnable    = 1'b1;
    bus.iValid = 1'b0;
    bus.iChar  = 5'd0;

    // Reset state
    repeat (2) @(posedge iCLK);
    @(negedge iCLK) chk("reset", dut_out, OFF_E);
    @(posedge iCLK);
    #1 iRST_n = 1'b1;
    @(negedge iCLK) chk("idle_ready", dut_out, RDY_E);
    #1 iEnable = 1'b0;
    @(negedge iCLK) chk("idle_disabled", dut_out, OFF_E);
    #1 iEnable = 1'b1;
    @(negedge iCLK) chk("idle_reenabled", dut_out, RDY_E);

    // Every code: letters, illegal 26..30 and space
    for (int code = 0; code < 32; code++) send(code);

    // 'E' then 'T' with iValid held: T accepted on E's first ready cycle
    start(4);
    push_char(4);
    push_char(19);
    #1 bus.iChar = 5'd19;
    cur_code = 419;
    repeat (17) @(posedge iCLK);
    #1 bus.iValid = 1'b0;
    wait_empty();

    // 'Q' with a stray valid pulse while busy and a reset glitch between edges
    start(16);
    push_char(16);
    #1 bus.iValid = 1'b0;
    repeat (10) @(posedge iCLK);
    #1 bus.iChar = 5'd0;
    bus.iValid = 1'b1;
    @(posedge iCLK);
    #1 bus.iValid = 1'b0;
    #1 iRST_n = 1'b0;
    #2 iRST_n = 1'b1;
    wait_empty();

    // Enable dropped during the 6th cycle of 'O'
    start(14);
    push_n(MARK_E, 6);
    push_n(OFF_E, 4);
    push_n(RDY_E, 1);
    #1 bus.iValid = 1'b0;
    repeat (5) @(posedge iCLK);
    #1 iEnable = 1'b0;
    repeat (5) @(posedge iCLK);
    #1 iEnable = 1'b1;
    wait_empty();
    send(4);

    // One-edge reset during the 'T' dash
    start(19);
    push_n(MARK_E, 4);
    push_n(OFF_E, 1);
    push_n(RDY_E, 1);
    #1 bus.iValid = 1'b0;
    repeat (3) @(posedge iCLK);
    #3 iRST_n = 1'b0;
    @(posedge iCLK);
    #7 iRST_n = 1'b1;
    wait_empty();
    send(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
